grf_wb_queue: RTL

- Write-back buffer sitting in front of the GRF write port.
- Accepts register writes from long-latency producers (e.g. the multiply/divide path) into a small in-order FIFO.
- Drains one entry per cycle into the GRF write port (regwe / write address / write data) whenever the main pipeline is not using that port.
- Provides two read-side lookup ports so decode can bypass values still queued and not yet committed to the GRF.

---
 rtl/grf_wb_queue.sv | 125 ++++++++++++
 1 files changed

// File: rtl/grf_wb_queue.sv
// grf_wb_queue: in-order write-back buffer in front of the GRF write port.
// Long-latency producers push register writes here. The queue drains one
// entry per cycle into the GRF whenever the main pipeline is not using the
// write port. Two combinational lookup ports let decode bypass values that
// are still queued.
//
// Handshake (enqueue side): a write transfers at the rising edge where
// enq_valid && enq_ready. enq_ready depends only on registered state
// (count != DEPTH), never on enq_valid or on a same-cycle drain. A producer
// that sees enq_ready low must hold enq_valid/enq_addr/enq_data stable.
// Writes to register 0 complete the handshake but are not stored.
module grf_wb_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [4:0]       enq_addr,
  input  logic [31:0]      enq_data,
  input  logic             wb_hold,
  output logic             regwe,
  output logic [4:0]       wb_addr,
  output logic [31:0]      wb_data,
  input  logic [4:0]       rd_addr1,
  output logic             rd_hit1,
  output logic [31:0]      rd_data1,
  input  logic [4:0]       rd_addr2,
  output logic             rd_hit2,
  output logic [31:0]      rd_data2,
  output logic [PTR_W:0]   count,
  output logic             empty
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [4:0]       r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic             w_enq;
  logic             w_deq;
  logic [PTR_W-1:0] w_age_idx [DEPTH];

  // Status and write-port outputs; full/empty come from the count only.
  assign count     = r_count;
  assign empty     = (r_count == '0);
  assign enq_ready = (r_count != DEPTH_CNT);
  assign regwe     = !empty && !wb_hold;
  assign wb_addr   = r_addr[r_head];
  assign wb_data   = r_data[r_head];

  // A register-0 write is acknowledged but never occupies a slot.
  assign w_enq = enq_valid && enq_ready && (enq_addr != 5'd0);
  assign w_deq = regwe;

  // Slot index ordered by age: element 0 is the head (oldest).
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_age_idx[i] = r_head + PTR_W'(i);
    end
  end

  // Port 1 lookup: walk oldest to youngest so the youngest match wins.
  always_comb begin
    rd_hit1  = 1'b0;
    rd_data1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[w_age_idx[i]] && (r_addr[w_age_idx[i]] == rd_addr1) &&
          (rd_addr1 != 5'd0)) begin
        rd_hit1  = 1'b1;
        rd_data1 = r_data[w_age_idx[i]];
      end
    end
  end

  // Port 2 lookup: same youngest-wins walk as port 1.
  always_comb begin
    rd_hit2  = 1'b0;
    rd_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[w_age_idx[i]] && (r_addr[w_age_idx[i]] == rd_addr2) &&
          (rd_addr2 != 5'd0)) begin
        rd_hit2  = 1'b1;
        rd_data2 = r_data[w_age_idx[i]];
      end
    end
  end

  // Queue storage, pointers and occupancy; enqueue and drain never touch
  // the same slot in one cycle because that would need count==DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_enq) begin
        r_addr[r_tail] <= enq_addr;
        r_data[r_tail] <= enq_data;
        r_vld[r_tail]  <= 1'b1;
        r_tail         <= r_tail + 1'b1;
      end
      if (w_deq) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + 1'b1;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
